// File: rtl/axil_gpio_pkg.sv
// Shared definitions for the AXI4-Lite GPIO slave: register offsets, response codes,
// channel state enums and the address decode helper.
package axil_gpio_pkg;

  localparam logic [4:0] LED_OFS     = 5'h00;
  localparam logic [4:0] SW_OFS      = 5'h04;
  localparam logic [4:0] EDGE_OFS    = 5'h08;
  localparam logic [4:0] SCRATCH_OFS = 5'h0C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_HAVE_AW = 2'd1,
    WR_HAVE_W  = 2'd2,
    WR_RESP    = 2'd3
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

  typedef enum logic [2:0] {
    REG_LED     = 3'd0,
    REG_SW      = 3'd1,
    REG_EDGE    = 3'd2,
    REG_SCRATCH = 3'd3,
    REG_NONE    = 3'd4
  } reg_sel_e;

  // Word index is addr[4:2]; the byte offsets above carry the same bits.
  function automatic reg_sel_e decode_reg(input logic [2:0] word);
    reg_sel_e sel;
    case (word)
      LED_OFS[4:2]:     sel = REG_LED;
      SW_OFS[4:2]:      sel = REG_SW;
      EDGE_OFS[4:2]:    sel = REG_EDGE;
      SCRATCH_OFS[4:2]: sel = REG_SCRATCH;
      default:          sel = REG_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Multi-flop synchronizer for asynchronous inputs; q is the last stage.
module gpio_in_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_r;

  // Shift chain: stage 0 samples the raw input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_r <= '0;
    end else begin
      stage_r <= {stage_r[STAGES-2:0], d};
    end
  end

  assign q = stage_r[STAGES-1];

endmodule

// File: rtl/axil_gpio_slave.sv
// AXI4-Lite GPIO slave: LED register, synchronized switch readback and scratch register.
// Defining AXIL_GPIO_EDGE_EN adds the sticky switch-change (SW_EDGE, RW1C) register at 0x08.
module axil_gpio_slave
  import axil_gpio_pkg::*;
#(
  parameter int         ADDR_WIDTH = 5,
  parameter logic [7:0] LED_RESET  = 8'h00
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [7:0]            led_o,
  input  logic [7:0]            sw_i
);

  logic        rdy_r;
  wr_state_e   wr_state_r, wr_state_nx_s;
  rd_state_e   rd_state_r, rd_state_nx_s;
  logic        awready_s, wready_s, arready_s;
  logic        aw_hs_s, w_hs_s, ar_hs_s, wr_commit_s;
  logic [2:0]  aw_word_r, wr_word_s;
  logic [31:0] w_data_r, wr_data_s;
  logic [3:0]  w_strb_r, wr_strb_s;
  reg_sel_e    wr_sel_s, rd_sel_s;
  logic [1:0]  wr_resp_s, rd_resp_s;
  logic [31:0] rd_data_s;
  logic        bvalid_r, rvalid_r;
  logic [1:0]  bresp_r, rresp_r;
  logic [31:0] rdata_r;
  logic [7:0]  led_r;
  logic [31:0] scratch_r;
  logic [7:0]  sw_sync_s;
  logic        unused_s;

  // Only addr[4:2] is decoded; the byte lane and any upper bits are ignored.
  assign unused_s = ^{s_axi_awaddr, s_axi_araddr};

  gpio_in_sync #(.WIDTH(8), .STAGES(2)) u_sw_sync (
    .clk   (aclk),
    .rst_n (aresetn),
    .d     (sw_i),
    .q     (sw_sync_s)
  );

  // Reset-done flag keeps all readies low for the first cycle after release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_r <= 1'b0;
    end else begin
      rdy_r <= 1'b1;
    end
  end

  assign aw_hs_s = s_axi_awvalid && awready_s;
  assign w_hs_s  = s_axi_wvalid && wready_s;
  assign ar_hs_s = s_axi_arvalid && arready_s;

  // Write FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_r <= WR_IDLE;
    end else begin
      wr_state_r <= wr_state_nx_s;
    end
  end

  // Write FSM next state: commit once both AW and W are in hand.
  always_comb begin
    wr_state_nx_s = wr_state_r;
    case (wr_state_r)
      WR_IDLE: begin
        if (aw_hs_s && w_hs_s) wr_state_nx_s = WR_RESP;
        else if (aw_hs_s)      wr_state_nx_s = WR_HAVE_AW;
        else if (w_hs_s)       wr_state_nx_s = WR_HAVE_W;
        else                   wr_state_nx_s = WR_IDLE;
      end
      WR_HAVE_AW: begin
        if (w_hs_s) wr_state_nx_s = WR_RESP;
        else        wr_state_nx_s = WR_HAVE_AW;
      end
      WR_HAVE_W: begin
        if (aw_hs_s) wr_state_nx_s = WR_RESP;
        else         wr_state_nx_s = WR_HAVE_W;
      end
      WR_RESP: begin
        if (s_axi_bready) wr_state_nx_s = WR_IDLE;
        else              wr_state_nx_s = WR_RESP;
      end
      default: wr_state_nx_s = WR_IDLE;
    endcase
  end

  // Write FSM outputs: a channel is ready while its own holding slot is empty.
  always_comb begin
    awready_s = 1'b0;
    wready_s  = 1'b0;
    case (wr_state_r)
      WR_IDLE: begin
        awready_s = rdy_r;
        wready_s  = rdy_r;
      end
      WR_HAVE_AW: wready_s  = rdy_r;
      WR_HAVE_W:  awready_s = rdy_r;
      default: begin
        awready_s = 1'b0;
        wready_s  = 1'b0;
      end
    endcase
  end

  assign wr_commit_s = (wr_state_r != WR_RESP) && (wr_state_nx_s == WR_RESP);

  // Holding registers for whichever of AW/W arrives first.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_word_r <= 3'd0;
      w_data_r  <= 32'h0000_0000;
      w_strb_r  <= 4'h0;
    end else begin
      if (aw_hs_s) aw_word_r <= s_axi_awaddr[4:2];
      if (w_hs_s) begin
        w_data_r <= s_axi_wdata;
        w_strb_r <= s_axi_wstrb;
      end
    end
  end

  // Commit operands come from the holding register or straight from the bus.
  always_comb begin
    if (wr_state_r == WR_HAVE_AW) begin
      wr_word_s = aw_word_r;
    end else begin
      wr_word_s = s_axi_awaddr[4:2];
    end
    if (wr_state_r == WR_HAVE_W) begin
      wr_data_s = w_data_r;
      wr_strb_s = w_strb_r;
    end else begin
      wr_data_s = s_axi_wdata;
      wr_strb_s = s_axi_wstrb;
    end
  end

  assign wr_sel_s = decode_reg(wr_word_s);
  assign rd_sel_s = decode_reg(s_axi_araddr[4:2]);

`ifdef AXIL_GPIO_EDGE_EN
  logic [7:0] sw_s3_r, edge_r, edge_clr_s;

  // W1C mask; only byte lane 0 can clear.
  always_comb begin
    if (wr_commit_s && (wr_sel_s == REG_EDGE) && wr_strb_s[0]) begin
      edge_clr_s = wr_data_s[7:0];
    end else begin
      edge_clr_s = 8'h00;
    end
  end

  // Sticky change detect; a new change on a bit overrides its clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sw_s3_r <= 8'h00;
      edge_r  <= 8'h00;
    end else begin
      sw_s3_r <= sw_sync_s;
      edge_r  <= (edge_r & ~edge_clr_s) | (sw_sync_s ^ sw_s3_r);
    end
  end
`endif

  // Write response code per target register.
  always_comb begin
    wr_resp_s = RESP_OKAY;
    case (wr_sel_s)
      REG_LED:     wr_resp_s = RESP_OKAY;
      REG_SW:      wr_resp_s = RESP_OKAY;
`ifdef AXIL_GPIO_EDGE_EN
      REG_EDGE:    wr_resp_s = RESP_OKAY;
`endif
      REG_SCRATCH: wr_resp_s = RESP_OKAY;
      default:     wr_resp_s = RESP_SLVERR;
    endcase
  end

  // Register updates and B channel, both on the commit edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      led_r     <= LED_RESET;
      scratch_r <= 32'h0000_0000;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
    end else begin
      if (wr_commit_s) begin
        bvalid_r <= 1'b1;
        bresp_r  <= wr_resp_s;
        if ((wr_sel_s == REG_LED) && wr_strb_s[0]) led_r <= wr_data_s[7:0];
        if (wr_sel_s == REG_SCRATCH) scratch_r <= apply_wstrb(scratch_r, wr_data_s, wr_strb_s);
      end else if (bvalid_r && s_axi_bready) begin
        bvalid_r <= 1'b0;
      end
    end
  end

  // Read mux over current register values.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    rd_resp_s = RESP_OKAY;
    case (rd_sel_s)
      REG_LED:     rd_data_s = {24'h00_0000, led_r};
      REG_SW:      rd_data_s = {24'h00_0000, sw_sync_s};
`ifdef AXIL_GPIO_EDGE_EN
      REG_EDGE:    rd_data_s = {24'h00_0000, edge_r};
`endif
      REG_SCRATCH: rd_data_s = scratch_r;
      default:     rd_resp_s = RESP_SLVERR;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_r <= RD_IDLE;
    end else begin
      rd_state_r <= rd_state_nx_s;
    end
  end

  // Read FSM next state: one read outstanding.
  always_comb begin
    rd_state_nx_s = rd_state_r;
    case (rd_state_r)
      RD_IDLE: begin
        if (ar_hs_s) rd_state_nx_s = RD_RESP;
        else         rd_state_nx_s = RD_IDLE;
      end
      RD_RESP: begin
        if (s_axi_rready) rd_state_nx_s = RD_IDLE;
        else              rd_state_nx_s = RD_RESP;
      end
      default: rd_state_nx_s = RD_IDLE;
    endcase
  end

  // Read FSM outputs.
  always_comb begin
    case (rd_state_r)
      RD_IDLE: arready_s = rdy_r;
      default: arready_s = 1'b0;
    endcase
  end

  // R channel registers, held until rready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid_r <= 1'b0;
      rdata_r  <= 32'h0000_0000;
      rresp_r  <= 2'b00;
    end else begin
      if (ar_hs_s) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rd_data_s;
        rresp_r  <= rd_resp_s;
      end else if (rvalid_r && s_axi_rready) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  assign s_axi_awready = awready_s;
  assign s_axi_wready  = wready_s;
  assign s_axi_arready = arready_s;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = rresp_r;
  assign led_o         = led_r;

endmodule

// File: tb/tb_axil_gpio_slave.sv
// Scoreboard bench for axil_gpio_slave: directed plan plus randomized traffic against a
// behavioural register model; a negedge monitor checks every B/R response.
module tb_axil_gpio_slave;

`ifdef AXIL_GPIO_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [4:0]  awaddr = 5'h0, araddr = 5'h0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  wstrb = 4'h0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [7:0]  led_o;
  logic [7:0]  sw_i = 8'h00;

  always #5 aclk = ~aclk;

  axil_gpio_slave #(.ADDR_WIDTH(5), .LED_RESET(8'h00)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .led_o(led_o), .sw_i(sw_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
  rexp_t      r_q[$];
  logic [1:0] b_q[$];

  // Behavioural register model
  logic [7:0]  m_led = 8'h00, m_sw = 8'h00, m_edge = 8'h00, sw_cur = 8'h00;
  logic [31:0] m_scratch = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_write(input logic [4:0] a, input logic [31:0] d,
                                             input logic [3:0] s);
    int idx = int'(a) / 4;
    if (idx == 0) begin
      if (s[0]) m_led = d[7:0];
      return 2'b00;
    end else if (idx == 1) begin
      return 2'b00;
    end else if (idx == 2 && EDGE_EN) begin
      if (s[0]) m_edge = m_edge & ~d[7:0];
      return 2'b00;
    end else if (idx == 3) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
      return 2'b00;
    end
    return 2'b10;
  endfunction

  function automatic rexp_t model_read(input logic [4:0] a);
    rexp_t e;
    int idx = int'(a) / 4;
    e.data = 32'h0;
    e.resp = 2'b00;
    if (idx == 0)                  e.data = {24'h0, m_led};
    else if (idx == 1)             e.data = {24'h0, m_sw};
    else if (idx == 2 && EDGE_EN)  e.data = {24'h0, m_edge};
    else if (idx == 3)             e.data = m_scratch;
    else                           e.resp = 2'b10;
    return e;
  endfunction

  // Monitor: response scoreboard, latency, stability and ready blocking.
  initial begin
    bit exp_b = 0, exp_r = 0, b_hold = 0, r_hold = 0;
    int aw_pend = 0, w_pend = 0;
    logic [1:0]  hold_bresp, hold_rresp;
    logic [31:0] hold_rdata;
    rexp_t re;
    logic [1:0] be;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        exp_b = 0; exp_r = 0; b_hold = 0; r_hold = 0; aw_pend = 0; w_pend = 0;
      end else begin
        if (exp_b) check("b_latency", {31'h0, bvalid}, 32'h1);
        if (exp_r) check("r_latency", {31'h0, rvalid}, 32'h1);
        if (b_hold) begin
          check("b_hold_valid", {31'h0, bvalid}, 32'h1);
          check("b_hold_resp", {30'h0, bresp}, {30'h0, hold_bresp});
        end
        if (r_hold) begin
          check("r_hold_valid", {31'h0, rvalid}, 32'h1);
          check("r_hold_data", rdata, hold_rdata);
          check("r_hold_resp", {30'h0, rresp}, {30'h0, hold_rresp});
        end
        if (bvalid) check("aw_w_blocked", {30'h0, awready, wready}, 32'h0);
        if (rvalid) check("ar_blocked", {31'h0, arready}, 32'h0);
        if (bvalid && bready) begin
          if (b_q.size() == 0) check("b_unexpected", 32'h1, 32'h0);
          else begin
            be = b_q.pop_front();
            check("bresp", {30'h0, bresp}, {30'h0, be});
          end
        end
        if (rvalid && rready) begin
          if (r_q.size() == 0) check("r_unexpected", 32'h1, 32'h0);
          else begin
            re = r_q.pop_front();
            check("rdata", rdata, re.data);
            check("rresp", {30'h0, rresp}, {30'h0, re.resp});
          end
        end
        b_hold = bvalid && !bready;  hold_bresp = bresp;
        r_hold = rvalid && !rready;  hold_rresp = rresp; hold_rdata = rdata;
        if (awvalid && awready) aw_pend++;
        if (wvalid && wready)   w_pend++;
        exp_b = 0;
        if (aw_pend > 0 && w_pend > 0) begin
          aw_pend--; w_pend--; exp_b = 1;
        end
        exp_r = arvalid && arready;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    b_q.push_back(model_write(a, d, s));
    fork
      begin
        bit ok = 0;
        tick(aw_dly);
        awaddr = a; awvalid = 1'b1;
        for (int t = 0; t < 64 && !ok; t++) begin @(negedge aclk); ok = awready; end
        if (!ok) check("aw_timeout", 32'h0, 32'h1);
        tick(1); awvalid = 1'b0;
      end
      begin
        bit ok = 0;
        tick(w_dly);
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int t = 0; t < 64 && !ok; t++) begin @(negedge aclk); ok = wready; end
        if (!ok) check("w_timeout", 32'h0, 32'h1);
        tick(1); wvalid = 1'b0;
      end
    join
    for (int t = 0; t < 64 && !bvalid; t++) @(negedge aclk);
    if (!bvalid) check("b_timeout", 32'h0, 32'h1);
    tick(1 + b_dly);
    bready = 1'b1;
    tick(1);
    bready = 1'b0;
    check("led_o", {24'h0, led_o}, {24'h0, m_led});
  endtask

  task automatic axi_read(input logic [4:0] a, input int ar_dly, input int r_dly);
    bit ok = 0;
    r_q.push_back(model_read(a));
    tick(ar_dly);
    araddr = a; arvalid = 1'b1;
    for (int t = 0; t < 64 && !ok; t++) begin @(negedge aclk); ok = arready; end
    if (!ok) check("ar_timeout", 32'h0, 32'h1);
    tick(1); arvalid = 1'b0;
    for (int t = 0; t < 64 && !rvalid; t++) @(negedge aclk);
    if (!rvalid) check("r_timeout", 32'h0, 32'h1);
    tick(1 + r_dly);
    rready = 1'b1;
    tick(1);
    rready = 1'b0;
  endtask

  task automatic set_sw(input logic [7:0] v);
    logic [7:0] old = sw_cur;
    sw_i = v; sw_cur = v;
    tick(4);
    m_sw = v;
    if (EDGE_EN) m_edge = m_edge | (old ^ v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge aclk);
    check("rst_readies", {29'h0, awready, wready, arready}, 32'h0);
    check("rst_valids", {30'h0, bvalid, rvalid}, 32'h0);
    check("rst_resp", {28'h0, bresp, rresp}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_led", {24'h0, led_o}, 32'h0);
    @(posedge aclk); #1 aresetn = 1'b1;
    @(negedge aclk);
    check("rdy_first_cycle", {29'h0, awready, wready, arready}, 32'h0);
    @(negedge aclk);
    check("rdy_after", {29'h0, awready, wready, arready}, 32'h7);
    @(posedge aclk); #1;

    // LED writes with AW and W together
    axi_write(5'h00, 32'h0000_0055, 4'hF, 0, 0, 0);
    axi_write(5'h00, 32'h0000_00AA, 4'hF, 0, 0, 0);
    // Switch readback
    set_sw(8'h44);
    axi_read(5'h04, 0, 0);
    set_sw(8'hBB);
    axi_read(5'h04, 0, 0);
    // W three cycles ahead of AW, partial strobe
    axi_write(5'h0C, 32'hDEAD_BEEF, 4'b0011, 3, 0, 0);
    axi_read(5'h0C, 0, 0);
    // Unmapped accesses
    axi_read(5'h14, 0, 0);
    axi_write(5'h10, 32'h1234_5678, 4'hF, 0, 0, 0);
    axi_read(5'h00, 0, 0);
    axi_read(5'h0C, 0, 0);
    // Sticky edge register (or unmapped 0x08)
    axi_read(5'h08, 0, 0);
    axi_write(5'h08, 32'h0000_000F, 4'h1, 0, 0, 0);
    axi_read(5'h08, 0, 0);
    // Backpressure
    axi_read(5'h0C, 0, 4);
    axi_write(5'h00, 32'h0000_0033, 4'h1, 1, 2, 4);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      logic [4:0] a;
      a = 5'(($urandom_range(0, 7)) * 4);
      if ($urandom_range(0, 9) == 0) set_sw(8'($urandom));
      if ($urandom_range(0, 1) == 0)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(a, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Reset with only AW accepted: the write must be abandoned
    awaddr = 5'h0C; awvalid = 1'b1;
    @(negedge aclk);
    tick(1); awvalid = 1'b0;
    aresetn = 1'b0;
    tick(2);
    @(negedge aclk);
    check("midrst_bvalid", {31'h0, bvalid}, 32'h0);
    check("midrst_led", {24'h0, led_o}, 32'h0);
    @(posedge aclk); #1 aresetn = 1'b1;
    m_led = 8'h00; m_scratch = 32'h0; m_edge = 8'h00; m_sw = sw_cur;
    if (EDGE_EN) m_edge = sw_cur;
    tick(5);
    wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
    tick(3);
    check("w_alone_no_b", {31'h0, bvalid}, 32'h0);
    wvalid = 1'b0;
    b_q.push_back(model_write(5'h0C, 32'hFFFF_FFFF, 4'hF));
    awaddr = 5'h0C; awvalid = 1'b1;
    tick(1); awvalid = 1'b0;
    for (int t = 0; t < 16 && !bvalid; t++) @(negedge aclk);
    tick(1); bready = 1'b1; tick(1); bready = 1'b0;
    axi_read(5'h00, 0, 0);
    axi_read(5'h0C, 0, 0);
    axi_read(5'h08, 0, 0);
    axi_read(5'h04, 0, 0);

    tick(3);
    check("b_queue_empty", b_q.size(), 32'h0);
    check("r_queue_empty", r_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
